enc_lane_scheduler: RTL

ENC_LANE_SCHEDULER -- requirements
Module: enc_lane_scheduler

---
 rtl/enc_lane_scheduler_if.sv | 34 +++
 rtl/enc_lane_scheduler.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/enc_lane_scheduler_if.sv
// Handshake and lane bus between the ordered-set/transport sources,
// the lane scheduler and the downstream symbol encoder.
interface enc_lane_scheduler_if;
  logic       sched_en;
  logic [1:0] gen_speed;
  logic       os_valid;
  logic [3:0] os_type;
  logic [7:0] os_lane_0;
  logic [7:0] os_lane_1;
  logic       os_ready;
  logic       tl_valid;
  logic [7:0] tl_lane_0;
  logic [7:0] tl_lane_1;
  logic       tl_ready;
  logic [7:0] lane_0_tx;
  logic [7:0] lane_1_tx;
  logic [3:0] d_sel;
  logic       enable;
  logic       sym_start;

  // Source/encoder side: drives requests, observes grants and lane output.
  modport master (
    output sched_en, gen_speed, os_valid, os_type, os_lane_0, os_lane_1,
    output tl_valid, tl_lane_0, tl_lane_1,
    input  os_ready, tl_ready, lane_0_tx, lane_1_tx, d_sel, enable, sym_start
  );

  // Scheduler side.
  modport slave (
    input  sched_en, gen_speed, os_valid, os_type, os_lane_0, os_lane_1,
    input  tl_valid, tl_lane_0, tl_lane_1,
    output os_ready, tl_ready, lane_0_tx, lane_1_tx, d_sel, enable, sym_start
  );
endinterface

// File: rtl/enc_lane_scheduler.sv
// Two-lane symbol scheduler: arbitrates ordered-set and transport byte
// pairs into whole symbols (1, 8 or 16 bytes depending on generation),
// with a burst limit so ordered sets cannot starve waiting transport data.
module enc_lane_scheduler #(
  parameter int OS_BURST_MAX = 4
) (
  input logic                  enc_clk,
  input logic                  rst,
  enc_lane_scheduler_if.slave  bus
);

  localparam int BW = (OS_BURST_MAX < 1) ? 1 : $clog2(OS_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(OS_BURST_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OS_SYM = 2'd1,
    TL_SYM = 2'd2
  } state_t;

  state_t        state_reg, state_next, pick;
  logic [3:0]    cnt_reg, cnt_next;      // byte index within symbol
  logic [3:0]    last_reg, last_next;    // latched L-1 of current symbol
  logic [BW-1:0] burst_reg, burst_next;  // OS symbols granted while TL waits
  logic [3:0]    os_type_reg;
  logic          req_ok, boundary;

  logic [7:0]    os_byte [2];
  logic [7:0]    tl_byte [2];
  logic [7:0]    lane_reg [2];
  logic [3:0]    d_sel_reg;
  logic          enable_reg, sym_start_reg;

  // Last byte index for a generation; reserved speed never starts a symbol.
  function automatic logic [3:0] sym_last(input logic [1:0] spd);
    case (spd)
      2'd1:    return 4'd15;
      2'd2:    return 4'd7;
      default: return 4'd0;
    endcase
  endfunction

  assign os_byte[0] = bus.os_lane_0;
  assign os_byte[1] = bus.os_lane_1;
  assign tl_byte[0] = bus.tl_lane_0;
  assign tl_byte[1] = bus.tl_lane_1;

  assign bus.os_ready  = (state_reg == OS_SYM);
  assign bus.tl_ready  = (state_reg == TL_SYM);
  assign bus.lane_0_tx = lane_reg[0];
  assign bus.lane_1_tx = lane_reg[1];
  assign bus.d_sel     = d_sel_reg;
  assign bus.enable    = enable_reg;
  assign bus.sym_start = sym_start_reg;

  // Next-symbol decision at IDLE or the last byte; otherwise advance the byte counter.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    burst_next = burst_reg;
    pick       = IDLE;
    req_ok     = bus.sched_en && (bus.gen_speed != 2'd3);
    boundary   = (state_reg == IDLE) || (cnt_reg == last_reg);

    if (req_ok && bus.tl_valid && (burst_reg == BURST_MAX)) begin
      pick = TL_SYM;
    end else if (req_ok && bus.os_valid) begin
      pick = OS_SYM;
    end else if (req_ok && bus.tl_valid) begin
      pick = TL_SYM;
    end

    if (boundary) begin
      state_next = pick;
      cnt_next   = 4'd0;
      // L is captured here so a gen_speed change only affects the next symbol.
      if (pick != IDLE) begin
        last_next = sym_last(bus.gen_speed);
      end
      if (pick == OS_SYM) begin
        if (bus.tl_valid) begin
          burst_next = burst_reg + 1'b1;
        end
      end else begin
        burst_next = '0;
      end
    end else begin
      cnt_next = cnt_reg + 4'd1;
    end
  end

  // FSM and counter registers; reset aborts any symbol in flight.
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      last_reg    <= 4'd0;
      burst_reg   <= '0;
      os_type_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
      burst_reg <= burst_next;
      if (state_reg == OS_SYM && cnt_reg == 4'd0) begin
        os_type_reg <= bus.os_type;
      end
    end
  end

  // Encoder control registered in step with the lane bytes.
  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      d_sel_reg     <= 4'd9;
      enable_reg    <= 1'b0;
      sym_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        OS_SYM: begin
          d_sel_reg     <= (cnt_reg == 4'd0) ? bus.os_type : os_type_reg;
          enable_reg    <= 1'b1;
          sym_start_reg <= (cnt_reg == 4'd0);
        end
        TL_SYM: begin
          d_sel_reg     <= 4'd8;
          enable_reg    <= 1'b1;
          sym_start_reg <= (cnt_reg == 4'd0);
        end
        default: begin
          d_sel_reg     <= 4'd9;
          enable_reg    <= 1'b0;
          sym_start_reg <= 1'b0;
        end
      endcase
    end
  end

  // Per-lane output byte: granted source byte, or zero when that source has no data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    always_ff @(posedge enc_clk or negedge rst) begin
      if (!rst) begin
        lane_reg[gi] <= 8'h00;
      end else begin
        case (state_reg)
          OS_SYM:  lane_reg[gi] <= bus.os_valid ? os_byte[gi] : 8'h00;
          TL_SYM:  lane_reg[gi] <= bus.tl_valid ? tl_byte[gi] : 8'h00;
          default: lane_reg[gi] <= 8'h00;
        endcase
      end
    end
  end

endmodule
